// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, FSM encoding and instruction field positions
//            for the ALU execute-stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control encodings (the ALU control equals the instruction op field)
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Instruction layout: [11:9] op, [8:6] rd, [5:3] rs, [2:0] rt
  localparam int INSTR_W = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 3;
  localparam int RT_MSB  = 2;
  localparam int RT_LSB  = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // True for the five op encodings the ALU implements
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_regfile
// Purpose  : NREG x DATA_W register file, two async operand read ports plus
//            an async debug read port, one sync write port, r0 hardwired 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] mem [NREG];

  // Storage: clears on reset, writes to r0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // r0 is forced to zero on every read port regardless of storage contents
  assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
  assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
  assign rdata_dbg = (raddr_dbg == '0) ? '0 : mem[raddr_dbg];

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Execute-stage sequencer around an external combinational 8-bit
//            ALU: accept, operand latch, execute, writeback (3 cycles/instr).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [11:0]       instr,
  output logic [DATA_W-1:0] alu_ina,
  output logic [DATA_W-1:0] alu_inb,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              done,
  output logic              illegal,
  output logic              zero_flag,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  state_t            state_next;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] result_q;
  logic              zq;

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              accept;
  logic              wr_en;

  assign accept = instr_valid && instr_ready;
  assign wr_en  = (state == WB) && op_is_legal(op_q);

  alu_exec_ctrl_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (wr_en),
    .waddr     (rd_q),
    .wdata     (result_q),
    .raddr_a   (instr[RS_MSB:RS_LSB]),
    .rdata_a   (rs_data),
    .raddr_b   (instr[RT_MSB:RT_LSB]),
    .rdata_b   (rt_data),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake/pulse outputs
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = WB;
      end
      WB: begin
        done       = 1'b1;
        illegal    = !op_is_legal(op_q);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch at accept, ALU capture in EXEC, zero flag update in WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      zq        <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= instr[OP_MSB:OP_LSB];
        rd_q  <= instr[RD_MSB:RD_LSB];
        opa_q <= rs_data;
        opb_q <= rt_data;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
        zq       <= alu_zero;
      end
      if (wr_en) zero_flag <= zq;
    end
  end

  // ALU inputs come straight from the latches so they hold while idle
  assign alu_ina  = opa_q;
  assign alu_inb  = opb_q;
  assign alu_ctrl = op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Purpose  : Self-checking bench for alu_exec_ctrl with a bench-side ALU,
//            an optional ALU stub and an array-based register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [11:0] instr;
  logic [7:0] alu_ina, alu_inb;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       done, illegal, zero_flag;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  logic       stub_en;
  logic [7:0] stub_val;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_reg [8];
  logic       model_zf;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_ina    (alu_ina),
    .alu_inb    (alu_inb),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .done       (done),
    .illegal    (illegal),
    .zero_flag  (zero_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Behavioural ALU from the opcode table
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // External ALU: real behaviour, or a bench-forced stub value
  always_comb begin
    alu_out  = stub_en ? stub_val : ref_alu(alu_ctrl, alu_ina, alu_inb);
    alu_zero = (alu_out == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sweep_dbg(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk($sformatf("%s_dbg_r%0d", tag, i), {24'd0, dbg_data}, {24'd0, model_reg[i]});
    end
  endtask

  // One full instruction: accept, EXEC, WB, back to IDLE; model updated at WB
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input bit hold_valid);
    logic [7:0] a, b, res;
    a = model_reg[rs];
    b = model_reg[rt];
    @(negedge clk);
    chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr       = {op, rd, rs, rt};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    chk("exec_ready_low", {31'd0, instr_ready}, 32'd0);
    chk("exec_done_low", {31'd0, done}, 32'd0);
    chk("exec_ctrl", {29'd0, alu_ctrl}, {29'd0, op});
    chk("exec_ina", {24'd0, alu_ina}, {24'd0, a});
    chk("exec_inb", {24'd0, alu_inb}, {24'd0, b});
    if (!hold_valid) instr_valid = 1'b0;
    else instr = {3'b010, 3'd6, 3'd1, 3'd1};
    res = stub_en ? stub_val : ref_alu(op, a, b);
    @(posedge clk); #1;
    chk("wb_done", {31'd0, done}, 32'd1);
    chk("wb_illegal", {31'd0, illegal}, {31'd0, !legal(op)});
    chk("wb_ready_low", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (legal(op)) begin
      if (rd != 3'd0) model_reg[rd] = res;
      model_zf = (res == 8'h00);
    end
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("zero_flag", {31'd0, zero_flag}, {31'd0, model_zf});
    dbg_addr = rd;
    #1;
    chk("dbg_rd", {24'd0, dbg_data}, {24'd0, model_reg[rd]});
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    stub_en     = 1'b0;
    stub_val    = '0;
    for (int i = 0; i < 8; i++) model_reg[i] = '0;
    model_zf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_ina", {24'd0, alu_ina}, 32'd0);
    chk("rst_alu_inb", {24'd0, alu_inb}, 32'd0);
    sweep_dbg("rst");

    // Preload r1=5 through the ALU stub, then ADD r3,r1,r2 with stub 0C
    stub_en = 1'b1; stub_val = 8'h05;
    run_instr(3'b010, 3'd1, 3'd0, 3'd0, 1'b0);
    stub_val = 8'h0C;
    run_instr(3'b010, 3'd3, 3'd1, 3'd2, 1'b0);
    chk("add_r3", {24'd0, model_reg[3]}, 32'h0C);

    // Real ALU: SUB r4,r1,r1 -> zero
    stub_en = 1'b0;
    run_instr(3'b110, 3'd4, 3'd1, 3'd1, 1'b0);
    chk("sub_zf_set", {31'd0, zero_flag}, 32'd1);

    // Write to r0 discarded but zero flag updated
    run_instr(3'b010, 3'd0, 3'd1, 3'd1, 1'b0);
    chk("r0_zf_clear", {31'd0, zero_flag}, 32'd0);

    // Illegal op with instr_valid held through EXEC/WB
    run_instr(3'b011, 3'd2, 3'd1, 3'd1, 1'b1);
    sweep_dbg("after_illegal");

    // Randomized sequences, sometimes seeding values through the stub
    for (int n = 0; n < 60; n++) begin
      stub_en  = ($urandom_range(0, 3) == 0);
      stub_val = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    end
    stub_en = 1'b0;
    sweep_dbg("random");

    // Reset during EXEC of ADD r5,r1,r1: aborted, regfile cleared
    stub_en = 1'b1; stub_val = 8'h05;
    run_instr(3'b010, 3'd1, 3'd0, 3'd0, 1'b0);
    stub_en = 1'b0;
    @(negedge clk);
    instr = {3'b010, 3'd5, 3'd1, 3'd1};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("pre_rst_exec", {31'd0, instr_ready}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model_reg[i] = '0;
    model_zf = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    chk("midrst_ready_idle", {31'd0, instr_ready}, 32'd1);
    chk("midrst_zero_flag", {31'd0, zero_flag}, 32'd0);
    sweep_dbg("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
